// File: rtl/fetch_unit.sv
//------------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage. Holds the fetch PC, issues one read at a time to
// the instruction memory, captures the returned word into InstrF and tells the
// hazard unit (FetchBusy) whether InstrF is usable. Branch/jump redirects from
// decode override the sequential PC+4 path and take effect even while the
// pipeline is stalled.
//
// Ports
//   CLK        clock, all state updates on the rising edge
//   RST        asynchronous, active-low reset
//   StallF     1 = hold the current fetched instruction and PC
//   PCSrcD     taken branch from decode, redirect to PCBranchD
//   PCBranchD  branch target
//   JumpD      jump from decode, redirect to PCJumpD (wins over PCSrcD)
//   PCJumpD    jump target
//   IMemReq    instruction-memory read request
//   IMemAddr   read address (always equal to PCF)
//   IMemRdata  read data, sampled only when IMemValid=1 in WAIT
//   IMemValid  read data valid, one pulse per request
//   InstrF     fetched instruction toward the decode pipeline register
//   PCPlus4F   PCF+4 (wraps modulo 2^ADDR_WIDTH)
//   PCF        current fetch PC
//   FetchBusy  1 = InstrF not valid
//------------------------------------------------------------------------------
module fetch_unit #(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    INSTR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(32'h0000_0000)
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   StallF,
   input  logic                   PCSrcD,
   input  logic [ADDR_WIDTH-1:0]  PCBranchD,
   input  logic                   JumpD,
   input  logic [ADDR_WIDTH-1:0]  PCJumpD,
   output logic                   IMemReq,
   output logic [ADDR_WIDTH-1:0]  IMemAddr,
   input  logic [INSTR_WIDTH-1:0] IMemRdata,
   input  logic                   IMemValid,
   output logic [INSTR_WIDTH-1:0] InstrF,
   output logic [ADDR_WIDTH-1:0]  PCPlus4F,
   output logic [ADDR_WIDTH-1:0]  PCF,
   output logic                   FetchBusy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      VALID = 2'd2
   } state_t;

   state_t                 state;
   logic                   drop;      // an abandoned request is still in flight
   logic                   redirect;
   logic [ADDR_WIDTH-1:0]  target_raw;
   logic [ADDR_WIDTH-1:0]  target;

   // Jump beats branch; the low two bits are cleared so the PC stays
   // word aligned no matter what decode hands us.
   assign redirect   = JumpD | PCSrcD;
   assign target_raw = JumpD ? PCJumpD : PCBranchD;
   assign target     = {target_raw[ADDR_WIDTH-1:2], 2'b00};

   assign PCPlus4F = PCF + ADDR_WIDTH'(4);
   assign IMemAddr = PCF;

   // IMemReq and FetchBusy are registered: every transition below also
   // writes the value they must carry in the state being entered.
   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // the pre-edge values of the others, independent of statement order.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         // NOTE: all fetch state sits on the asynchronous reset so an
         // in-flight request is abandoned immediately, without a clock.
         state     <= IDLE;
         PCF       <= RESET_PC;
         InstrF    <= '0;
         drop      <= 1'b0;
         IMemReq   <= 1'b0;
         FetchBusy <= 1'b1;
      end else begin
         case (state)
            // One dead cycle after reset; any stray IMemValid here belongs
            // to a request that reset already abandoned.
            IDLE: begin
               state     <= WAIT;
               IMemReq   <= 1'b1;
               FetchBusy <= 1'b1;
            end

            WAIT: begin
               if (drop) begin
                  // Request line is low; waiting only for the stale response.
                  // Later redirects simply retarget the PC.
                  if (redirect) begin
                     PCF <= target;
                  end
                  if (IMemValid) begin
                     drop    <= 1'b0;
                     IMemReq <= 1'b1;
                  end
               end else if (redirect) begin
                  PCF <= target;
                  if (!IMemValid) begin
                     // Response still pending: must swallow it before a new
                     // request can go out (one outstanding at a time).
                     drop    <= 1'b1;
                     IMemReq <= 1'b0;
                  end
                  // With IMemValid the old data is discarded and the request
                  // stays up, now pointing at the target.
               end else if (IMemValid) begin
                  InstrF    <= IMemRdata;
                  state     <= VALID;
                  IMemReq   <= 1'b0;
                  FetchBusy <= 1'b0;
               end
            end

            VALID: begin
               if (redirect) begin
                  // Redirect ignores StallF; the wrong-path word is flushed.
                  PCF       <= target;
                  InstrF    <= '0;
                  state     <= WAIT;
                  IMemReq   <= 1'b1;
                  FetchBusy <= 1'b1;
               end else if (!StallF) begin
                  PCF       <= PCPlus4F;
                  state     <= WAIT;
                  IMemReq   <= 1'b1;
                  FetchBusy <= 1'b1;
               end
            end

            default: begin
               state     <= IDLE;
               drop      <= 1'b0;
               IMemReq   <= 1'b0;
               FetchBusy <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
//------------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit. A small behavioural instruction memory with
// programmable latency answers requests on the falling edge; outputs are
// sampled 1 time unit after the rising edge. A second instance with
// RESET_PC = FFFF_FFFC and a zero-wait memory covers the PC wrap.
//------------------------------------------------------------------------------
module tb_fetch_unit;

   logic        CLK;
   logic        RST;
   logic        StallF;
   logic        PCSrcD;
   logic [31:0] PCBranchD;
   logic        JumpD;
   logic [31:0] PCJumpD;
   logic        IMemReq;
   logic [31:0] IMemAddr;
   logic [31:0] IMemRdata;
   logic        IMemValid;
   logic [31:0] InstrF;
   logic [31:0] PCPlus4F;
   logic [31:0] PCF;
   logic        FetchBusy;

   // wrap instance
   logic        IMemReq2;
   logic [31:0] IMemAddr2;
   logic [31:0] InstrF2;
   logic [31:0] PCPlus4F2;
   logic [31:0] PCF2;
   logic        FetchBusy2;
   logic        IMemValid2;

   int n_cmp;
   int n_err;

   // memory model state
   bit          mem_en;
   int          lat;
   bit          mem_out;
   int          mem_cnt;
   logic [31:0] mem_a;

   fetch_unit dut (
      .CLK       (CLK),
      .RST       (RST),
      .StallF    (StallF),
      .PCSrcD    (PCSrcD),
      .PCBranchD (PCBranchD),
      .JumpD     (JumpD),
      .PCJumpD   (PCJumpD),
      .IMemReq   (IMemReq),
      .IMemAddr  (IMemAddr),
      .IMemRdata (IMemRdata),
      .IMemValid (IMemValid),
      .InstrF    (InstrF),
      .PCPlus4F  (PCPlus4F),
      .PCF       (PCF),
      .FetchBusy (FetchBusy)
   );

   assign IMemValid2 = IMemReq2;

   fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
      .CLK       (CLK),
      .RST       (RST),
      .StallF    (1'b0),
      .PCSrcD    (1'b0),
      .PCBranchD (32'h0),
      .JumpD     (1'b0),
      .PCJumpD   (32'h0),
      .IMemReq   (IMemReq2),
      .IMemAddr  (IMemAddr2),
      .IMemRdata (32'h1234_5678),
      .IMemValid (IMemValid2),
      .InstrF    (InstrF2),
      .PCPlus4F  (PCPlus4F2),
      .PCF       (PCF2),
      .FetchBusy (FetchBusy2)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a == 32'h0) ? 32'h2008_0005 : {16'hC0DE, a[15:0]};
   endfunction

   // Memory: latches the address when a request is seen, answers with a
   // one-cycle IMemValid pulse in the lat-th cycle, independent of whether
   // IMemReq stays high (so dropped requests still return).
   always @(negedge CLK) begin
      if (mem_en) begin
         if (!RST) begin
            mem_out   = 1'b0;
            IMemValid = 1'b0;
         end else begin
            IMemValid = 1'b0;
            if (!mem_out && IMemReq) begin
               mem_out = 1'b1;
               mem_a   = IMemAddr;
               mem_cnt = 0;
            end
            if (mem_out) begin
               if (mem_cnt == lat - 1) begin
                  IMemValid = 1'b1;
                  IMemRdata = mem_word(mem_a);
                  mem_out   = 1'b0;
               end else begin
                  mem_cnt = mem_cnt + 1;
               end
            end
         end
      end
   end

   task automatic do_reset();
      RST       = 1'b0;
      StallF    = 1'b0;
      PCSrcD    = 1'b0;
      JumpD     = 1'b0;
      PCBranchD = 32'h0;
      PCJumpD   = 32'h0;
      repeat (2) @(negedge CLK);
      RST = 1'b1;
   endtask

   task automatic test_reset();
      RST = 1'b0;
      repeat (2) @(negedge CLK);
      n_cmp++;
      if ({IMemReq, FetchBusy} !== 2'b01) begin
         n_err++;
         $display("FAIL reset_ctl: req/busy=%b expected 01", {IMemReq, FetchBusy});
      end
      n_cmp++;
      if (PCF !== 32'h0 || InstrF !== 32'h0) begin
         n_err++;
         $display("FAIL reset_pc_instr: PCF=%h InstrF=%h expected 0/0", PCF, InstrF);
      end
      n_cmp++;
      if (PCPlus4F !== 32'h4 || IMemAddr !== 32'h0) begin
         n_err++;
         $display("FAIL reset_plus4: PCPlus4F=%h IMemAddr=%h expected 4/0", PCPlus4F, IMemAddr);
      end
   endtask

   task automatic test_wrap();
      RST = 1'b0;
      @(negedge CLK);
      n_cmp++;
      if (PCF2 !== 32'hFFFF_FFFC || PCPlus4F2 !== 32'h0) begin
         n_err++;
         $display("FAIL wrap_reset: PCF=%h PCPlus4F=%h expected fffffffc/0", PCF2, PCPlus4F2);
      end
      @(negedge CLK);
      RST = 1'b1;
      @(posedge CLK); #1;
      n_cmp++;
      if (IMemReq2 !== 1'b1 || IMemAddr2 !== 32'hFFFF_FFFC) begin
         n_err++;
         $display("FAIL wrap_req: req=%b addr=%h expected 1/fffffffc", IMemReq2, IMemAddr2);
      end
      @(posedge CLK); #1;
      n_cmp++;
      if (InstrF2 !== 32'h1234_5678 || FetchBusy2 !== 1'b0) begin
         n_err++;
         $display("FAIL wrap_valid: InstrF=%h busy=%b expected 12345678/0", InstrF2, FetchBusy2);
      end
      @(posedge CLK); #1;
      n_cmp++;
      if (PCF2 !== 32'h0 || PCPlus4F2 !== 32'h4) begin
         n_err++;
         $display("FAIL wrap_advance: PCF=%h PCPlus4F=%h expected 0/4", PCF2, PCPlus4F2);
      end
   endtask

   task automatic test_zero_wait();
      lat = 1;
      do_reset();
      @(posedge CLK); #1;
      n_cmp++;
      if (IMemReq !== 1'b1 || IMemAddr !== 32'h0 || FetchBusy !== 1'b1) begin
         n_err++;
         $display("FAIL zw_req: req=%b addr=%h busy=%b expected 1/0/1", IMemReq, IMemAddr, FetchBusy);
      end
      @(posedge CLK); #1;
      n_cmp++;
      if (InstrF !== 32'h2008_0005 || PCPlus4F !== 32'h4 || FetchBusy !== 1'b0) begin
         n_err++;
         $display("FAIL zw_valid: InstrF=%h PCPlus4F=%h busy=%b expected 20080005/4/0",
                  InstrF, PCPlus4F, FetchBusy);
      end
   endtask

   task automatic test_latency();
      logic [31:0] exp_pc;
      lat = 3;
      do_reset();
      for (int k = 0; k < 3; k++) begin
         exp_pc = 32'(4 * k);
         for (int c = 0; c < 3; c++) begin
            @(posedge CLK); #1;
            n_cmp++;
            if (IMemReq !== 1'b1 || IMemAddr !== exp_pc || PCF !== exp_pc || FetchBusy !== 1'b1) begin
               n_err++;
               $display("FAIL lat_wait k=%0d c=%0d: req=%b addr=%h pc=%h busy=%b expected 1/%h/%h/1",
                        k, c, IMemReq, IMemAddr, PCF, FetchBusy, exp_pc, exp_pc);
            end
         end
         @(posedge CLK); #1;
         n_cmp++;
         if (FetchBusy !== 1'b0 || IMemReq !== 1'b0 || InstrF !== mem_word(exp_pc)) begin
            n_err++;
            $display("FAIL lat_valid k=%0d: busy=%b req=%b InstrF=%h expected 0/0/%h",
                     k, FetchBusy, IMemReq, InstrF, mem_word(exp_pc));
         end
      end
   endtask

   task automatic test_stall_and_jump();
      bit found;
      lat   = 1;
      found = 1'b0;
      do_reset();
      for (int i = 0; i < 20 && !found; i++) begin
         @(posedge CLK); #1;
         if (!FetchBusy && PCF == 32'h10) found = 1'b1;
      end
      n_cmp++;
      if (!found) begin
         n_err++;
         $display("FAIL stall_reach: VALID at 0x10 not reached, PCF=%h busy=%b", PCF, FetchBusy);
      end
      StallF = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge CLK); #1;
         n_cmp++;
         if (PCF !== 32'h10 || InstrF !== 32'hC0DE_0010 || PCPlus4F !== 32'h14 ||
             IMemReq !== 1'b0 || FetchBusy !== 1'b0) begin
            n_err++;
            $display("FAIL stall_hold %0d: pc=%h instr=%h plus4=%h req=%b busy=%b expected 10/c0de0010/14/0/0",
                     i, PCF, InstrF, PCPlus4F, IMemReq, FetchBusy);
         end
      end
      // Jump and branch together while still stalled: jump must win.
      JumpD     = 1'b1;
      PCJumpD   = 32'h40;
      PCSrcD    = 1'b1;
      PCBranchD = 32'h80;
      @(posedge CLK); #1;
      JumpD  = 1'b0;
      PCSrcD = 1'b0;
      StallF = 1'b0;
      n_cmp++;
      if (PCF !== 32'h40 || InstrF !== 32'h0 || IMemReq !== 1'b1 || IMemAddr !== 32'h40 ||
          FetchBusy !== 1'b1) begin
         n_err++;
         $display("FAIL jump_prio: pc=%h instr=%h req=%b addr=%h busy=%b expected 40/0/1/40/1",
                  PCF, InstrF, IMemReq, IMemAddr, FetchBusy);
      end
      @(posedge CLK); #1;
      n_cmp++;
      if (InstrF !== 32'hC0DE_0040 || FetchBusy !== 1'b0) begin
         n_err++;
         $display("FAIL jump_fetch: instr=%h busy=%b expected c0de0040/0", InstrF, FetchBusy);
      end
   endtask

   task automatic test_redirect_same_cycle();
      lat = 1;
      do_reset();
      @(posedge CLK); #1;
      JumpD   = 1'b1;
      PCJumpD = 32'h106;
      @(posedge CLK); #1;
      JumpD = 1'b0;
      n_cmp++;
      if (PCF !== 32'h104 || IMemReq !== 1'b1 || InstrF !== 32'h0 || FetchBusy !== 1'b1) begin
         n_err++;
         $display("FAIL same_cycle_redirect: pc=%h req=%b instr=%h busy=%b expected 104/1/0/1",
                  PCF, IMemReq, InstrF, FetchBusy);
      end
      @(posedge CLK); #1;
      n_cmp++;
      if (InstrF !== 32'hC0DE_0104 || FetchBusy !== 1'b0) begin
         n_err++;
         $display("FAIL same_cycle_fetch: instr=%h busy=%b expected c0de0104/0", InstrF, FetchBusy);
      end
   endtask

   task automatic test_redirect_wait();
      bit found;
      lat   = 3;
      found = 1'b0;
      do_reset();
      for (int i = 0; i < 20 && !found; i++) begin
         @(posedge CLK); #1;
         if (IMemReq && PCF == 32'h8) found = 1'b1;
      end
      n_cmp++;
      if (!found) begin
         n_err++;
         $display("FAIL drop_reach: WAIT at 0x8 not reached, PCF=%h req=%b", PCF, IMemReq);
      end
      PCSrcD    = 1'b1;
      PCBranchD = 32'h23;
      @(posedge CLK); #1;
      PCSrcD = 1'b0;
      n_cmp++;
      if (PCF !== 32'h20 || IMemReq !== 1'b0 || FetchBusy !== 1'b1) begin
         n_err++;
         $display("FAIL drop_redirect: pc=%h req=%b busy=%b expected 20/0/1", PCF, IMemReq, FetchBusy);
      end
      @(posedge CLK); #1;
      n_cmp++;
      if (IMemReq !== 1'b0 || FetchBusy !== 1'b1) begin
         n_err++;
         $display("FAIL drop_hold: req=%b busy=%b expected 0/1", IMemReq, FetchBusy);
      end
      // stale response for 0x8 arrives before this edge
      @(posedge CLK); #1;
      n_cmp++;
      if (IMemReq !== 1'b1 || IMemAddr !== 32'h20 || FetchBusy !== 1'b1 || InstrF !== 32'hC0DE_0004) begin
         n_err++;
         $display("FAIL drop_reissue: req=%b addr=%h busy=%b instr=%h expected 1/20/1/c0de0004",
                  IMemReq, IMemAddr, FetchBusy, InstrF);
      end
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(posedge CLK); #1;
         if (!FetchBusy) found = 1'b1;
      end
      n_cmp++;
      if (!found || InstrF !== 32'hC0DE_0020 || PCF !== 32'h20) begin
         n_err++;
         $display("FAIL drop_target_fetch: done=%b instr=%h pc=%h expected 1/c0de0020/20",
                  found, InstrF, PCF);
      end
   endtask

   task automatic test_late_valid();
      lat    = 1;
      mem_en = 1'b0;
      IMemValid = 1'b0;
      do_reset();
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      RST = 1'b0;
      #1;
      n_cmp++;
      if (IMemReq !== 1'b0 || FetchBusy !== 1'b1 || PCF !== 32'h0) begin
         n_err++;
         $display("FAIL midreq_reset: req=%b busy=%b pc=%h expected 0/1/0", IMemReq, FetchBusy, PCF);
      end
      @(negedge CLK);
      RST       = 1'b1;
      IMemValid = 1'b1;
      IMemRdata = 32'hDEAD_BEEF;
      @(posedge CLK); #1;
      IMemValid = 1'b0;
      n_cmp++;
      if (IMemReq !== 1'b1 || InstrF !== 32'h0 || FetchBusy !== 1'b1) begin
         n_err++;
         $display("FAIL late_valid_idle: req=%b instr=%h busy=%b expected 1/0/1", IMemReq, InstrF, FetchBusy);
      end
      @(posedge CLK); #1;
      n_cmp++;
      if (FetchBusy !== 1'b1 || InstrF !== 32'h0) begin
         n_err++;
         $display("FAIL late_valid_ignored: busy=%b instr=%h expected 1/0", FetchBusy, InstrF);
      end
      mem_out = 1'b0;
      mem_en  = 1'b1;
      @(posedge CLK); #1;
      n_cmp++;
      if (FetchBusy !== 1'b0 || InstrF !== 32'h2008_0005) begin
         n_err++;
         $display("FAIL late_valid_recover: busy=%b instr=%h expected 0/20080005", FetchBusy, InstrF);
      end
   endtask

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      mem_en    = 1'b1;
      lat       = 1;
      mem_out   = 1'b0;
      mem_cnt   = 0;
      mem_a     = 32'h0;
      IMemValid = 1'b0;
      IMemRdata = 32'h0;
      RST       = 1'b0;
      StallF    = 1'b0;
      PCSrcD    = 1'b0;
      JumpD     = 1'b0;
      PCBranchD = 32'h0;
      PCJumpD   = 32'h0;

      test_reset();
      test_wrap();
      test_zero_wait();
      test_latency();
      test_stall_and_jump();
      test_redirect_same_cycle();
      test_redirect_wait();
      test_late_valid();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, sets PC and instruction-memory address width.
REQ-002 Parameter INSTR_WIDTH, default 32, sets instruction word width.
REQ-003 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded on reset.
REQ-004 CLK  input  1  clock; all state updates on rising edge.
REQ-005 RST  input  1  asynchronous, active-low reset.
REQ-006 StallF  input  1  hazard-unit stall; 1 = hold current fetched instruction and PC.
REQ-007 PCSrcD  input  1  taken branch from decode; redirect to PCBranchD.
REQ-008 PCBranchD  input  ADDR_WIDTH  branch target.
REQ-009 JumpD  input  1  jump from decode; redirect to PCJumpD.
REQ-010 PCJumpD  input  ADDR_WIDTH  jump target.
REQ-011 IMemReq  output  1  instruction-memory read request.
REQ-012 IMemAddr  output  ADDR_WIDTH  read address, equal to PCF.
REQ-013 IMemRdata  input  INSTR_WIDTH  read data, sampled only when IMemValid=1.
REQ-014 IMemValid  input  1  read data valid, one pulse per request.
REQ-015 InstrF  output  INSTR_WIDTH  fetched instruction toward the decode pipeline register.
REQ-016 PCPlus4F  output  ADDR_WIDTH  PCF+4 toward the decode pipeline register.
REQ-017 PCF  output  ADDR_WIDTH  current fetch PC.
REQ-018 FetchBusy  output  1  1 = InstrF not valid; the hazard unit holds the decode register.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, WAIT, VALID.
REQ-020 IDLE: IMemReq=0, FetchBusy=1; unconditional move to WAIT on the next edge.
REQ-021 WAIT: IMemReq=1, IMemAddr=PCF, held stable until IMemValid; at most one outstanding request.
REQ-022 WAIT with IMemValid=1 and no redirect: InstrF<=IMemRdata; next state VALID.
REQ-023 WAIT with a redirect and IMemValid=1 in the same cycle: data discarded; PCF<=target; remain in WAIT, issuing the new address next cycle.
REQ-024 WAIT with a redirect and IMemValid=0: PCF<=target; the in-flight response SHALL be dropped (one-bit drop flag); IMemReq=0 until the dropped IMemValid arrives; then WAIT for target.
REQ-025 VALID: FetchBusy=0, IMemReq=0; InstrF and PCF held while StallF=1.
REQ-026 VALID with a redirect: PCF<=target; InstrF<=0; next state WAIT; a redirect SHALL take effect regardless of StallF.
REQ-027 VALID with StallF=0 and no redirect: PCF<=PCF+4; next state WAIT.
REQ-028 Redirect priority: JumpD over PCSrcD; PCSrcD over sequential increment.
REQ-029 Targets SHALL have bits [1:0] forced to 0 before loading PCF.
REQ-030 PCPlus4F SHALL be combinational PCF+4, modulo 2^ADDR_WIDTH (wrap FFFF_FFFC -> 0000_0000).
REQ-031 FetchBusy SHALL be 1 in IDLE and WAIT (including while dropping a response).
REQ-032 IMemValid with no outstanding request SHALL be ignored.
REQ-033 Minimum issue rate: one instruction per 2 cycles (zero-wait memory).

Reset
REQ-034 On RST=0, asynchronously: state=IDLE, PCF=RESET_PC, InstrF=0, drop flag=0, IMemReq=0, FetchBusy=1.
REQ-035 Reset mid-request SHALL abandon the request; a late IMemValid after reset release SHALL be ignored while in IDLE.

Verification
REQ-036 Reset release, zero-wait memory returning 32'h2008_0005 -> IMemReq=1 at PC 0x0; InstrF=32'h2008_0005, PCPlus4F=0x4, FetchBusy=0 two edges later.
REQ-037 3-cycle memory latency, StallF=0 -> PCF sequence 0x0, 0x4, 0x8; each IMemAddr held stable for 3 cycles; FetchBusy=1 throughout each wait.
REQ-038 VALID at PCF=0x10, StallF=1 for 4 cycles -> PCF, InstrF, PCPlus4F=0x14 unchanged; no IMemReq.
REQ-039 VALID, JumpD=1 with PCJumpD=0x40 and PCSrcD=1 with PCBranchD=0x80 in the same cycle -> PCF=0x40, InstrF=0, next request at 0x40.
REQ-040 WAIT at 0x8, PCSrcD=1 with PCBranchD=0x23, IMemValid 2 cycles later -> PCF=0x20; old data dropped; IMemReq=0 until the drop; then request at 0x20.
REQ-041 RESET_PC=32'hFFFF_FFFC -> PCPlus4F=0x0; after advancing, PCF=0x0.
